// File: rtl/pwm_core_if.sv
// ---------------------------------------------------------------------------
// pwm_core_if
// Groups the duty-value input and the PWM outputs of pwm_core into one bundle.
//
// Signals
//   compare       WIDTH  duty value, high ticks per period (controller -> core)
//   pwm           1      registered PWM output, active high (core -> controller)
//   period_start  1      one-clock strobe at the start of each period
//
// Modports
//   master  the controller: drives compare, observes pwm/period_start
//   slave   the PWM core:   reads compare, drives pwm/period_start
//
// Handshake: none. compare is sampled on the clock edge where the counter is
// at zero; the controller keeps it stable around that edge.
// ---------------------------------------------------------------------------
interface pwm_core_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] compare;
    logic             pwm;
    logic             period_start;

    modport master (
        output compare,
        input  pwm,
        input  period_start
    );

    modport slave (
        input  compare,
        output pwm,
        output period_start
    );
endinterface

// File: rtl/pwm_core.sv
// ---------------------------------------------------------------------------
// pwm_core
// Single-channel PWM generator. A free-running WIDTH-bit counter is compared
// against a duty value that is latched once per period (at counter zero), so
// a duty change mid-period never glitches the waveform.
//
// Parameters
//   WIDTH     counter/compare width; period = 2**WIDTH ticks
//   PRESCALE  clocks per counter tick (>=1); only used when PWM_PRESCALE_EN
//             is defined
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset
//   bus   pwm_core_if.slave: compare (in), pwm (out), period_start (out)
//
// Configuration macro
//   PWM_PRESCALE_EN  when defined, a prescaler divides the clock so the
//                    counter advances once every PRESCALE clocks. When
//                    undefined, the counter advances every clock.
//
// Timing: pwm and period_start are registered and reflect the counter value
// from one clock earlier. compare=0 gives a constant low output; the maximum
// compare gives 2**WIDTH-1 high ticks per period (100% is unreachable).
// ---------------------------------------------------------------------------
module pwm_core #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    pwm_core_if.slave  bus
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] eff;
    logic             tick;
    logic             pwm_q;
    logic             period_start_q;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // At the zero tick the freshly presented compare is used directly, so the
    // new duty applies to the very first tick of its own period.
    assign eff = cnt_zero ? bus.compare : shadow;

`ifdef PWM_PRESCALE_EN
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pre <= '0;
                end else if (pre == PRE_LAST) begin
                    pre <= '0;
                end else begin
                    pre <= pre + PW'(1);
                end
            end

            assign tick = (pre == PRE_LAST);
        end else begin : g_no_prescale
            assign tick = 1'b1;
        end
    endgenerate
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            shadow         <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            // Strobe lasts exactly one clock even when ticks are prescaled.
            period_start_q <= tick && cnt_zero;
            if (tick) begin
                cnt   <= cnt + WIDTH'(1);   // natural wrap at 2**WIDTH-1
                pwm_q <= (cnt < eff);
                if (cnt_zero) begin
                    shadow <= bus.compare;
                end
            end
        end
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_core.sv
// ---------------------------------------------------------------------------
// tb_pwm_core
// Drives a sequence of duty values into pwm_core, one per period, changing
// each value in the middle of the preceding period. The expected high-clock
// count of every period is queued when its duty value is driven; a monitor
// measures each completed period (high clocks, length, contiguity) and
// compares it against the queue head. Also covers reset values, asynchronous
// reset with the clock stopped, and restart timing.
// ---------------------------------------------------------------------------
module tb_pwm_core;

`ifdef PWM_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif
    localparam int WIDTH   = 8;
    localparam int PER_LEN = PS * (1 << WIDTH);
    localparam int W       = 16;
    localparam int NV      = 16;

    logic clk;
    logic rst;
    logic clk_run;

    pwm_core_if #(.WIDTH(WIDTH)) bus ();

    pwm_core #(
        .WIDTH    (WIDTH),
        .PRESCALE (PS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_duty(input logic [WIDTH-1:0] v);
        bus.compare = v;
        exp_q.push_back(W'(int'(v) * PS));
    endtask

    // ---------------- monitor ----------------
    logic mon_en;
    int   in_period = 0;
    int   high      = 0;
    int   len       = 0;
    int   contig    = 1;
    int   seen_low  = 0;
    int   periods   = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.period_start) begin
                if (in_period != 0) begin
                    check("q_nonempty", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        check("high_count", high, int'(exp_q.pop_front()));
                    end
                    check("period_len", len, PER_LEN);
                    check("contiguous", contig, 1);
                    periods++;
                end
                in_period = 1;
                high      = 0;
                len       = 0;
                contig    = 1;
                seen_low  = 0;
            end
            if (in_period != 0) begin
                len++;
                if (bus.pwm) begin
                    if (seen_low != 0) contig = 0;
                    high++;
                end else begin
                    seen_low = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] vals [NV];

    initial begin
        vals = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd10, 8'd10, 8'd128,
                 8'd230, 8'd240, 8'd250, 8'd4, 8'd14, 8'd1, 8'd0, 8'd0};
        vals[13] = WIDTH'($urandom_range(1, 254));
        vals[14] = WIDTH'($urandom_range(1, 254));

        clk_run     = 1'b1;
        mon_en      = 1'b0;
        rst         = 1'b0;
        bus.compare = '0;

        // Reset values with the clock running.
        step(3);
        check("rst_pwm", int'(bus.pwm), 0);
        check("rst_ps", int'(bus.period_start), 0);

        // First release: period_start and pwm rise after the first tick.
        bus.compare = 8'd200;
        rst = 1'b1;
        step(PS);
        check("first_ps", int'(bus.period_start), 1);
        check("first_pwm", int'(bus.pwm), 1);

        // Stop the clock (low), assert reset: outputs must clear with no edge.
        clk_run = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_pwm", int'(bus.pwm), 0);
        check("async_ps", int'(bus.period_start), 0);
        #4 rst = 1'b1;
        drive_duty(vals[0]);
        mon_en = 1'b1;
        #1 clk_run = 1'b1;

        // Restart: the period begins with the first tick after release.
        step(PS);
        check("restart_ps", int'(bus.period_start), 1);

        // One duty value per period, each changed 50 ticks into the
        // preceding period so it must wait for the next zero tick.
        for (int k = 1; k < NV; k++) begin
            step(50 * PS);
            drive_duty(vals[k]);
            step(PER_LEN - 50 * PS);
        end
        step(1);

        check("periods_seen", periods, NV - 1);
        check("leftover", exp_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #(20 * NV * PER_LEN + 10000);
        $display("FAIL timeout: got 0 expected 1 (run did not finish)");
        $fatal(1, "timeout");
    end

endmodule
